// File: rtl/operand_fetch_pkg.sv
// processor_pkg: shared definitions for the operand fetch stage.
//   XLEN        data width of registers and operands
//   NREGS       number of architectural registers (x0 reads as zero)
//   IDX_W       register index width
//   ALU_CTRL_W  ALU control code width
//   of_req_t    decoded op as presented to operand fetch
//   src_hit     true when a live writeback targets a given source index
package processor_pkg;

    localparam int XLEN       = 32;
    localparam int NREGS      = 32;
    localparam int IDX_W      = $clog2(NREGS);
    localparam int ALU_CTRL_W = 5;

    typedef struct packed {
        logic [IDX_W-1:0]      rs1;
        logic [IDX_W-1:0]      rs2;
        logic [IDX_W-1:0]      rd;
        logic [ALU_CTRL_W-1:0] alu_control;
        logic                  use_imm;
        logic [XLEN-1:0]       imm;
    } of_req_t;

    // A write to x0 never lands, so it can never collide with a source read.
    function automatic logic src_hit(input logic             wb_en,
                                     input logic [IDX_W-1:0] wb_idx,
                                     input logic [IDX_W-1:0] src);
        return wb_en && (wb_idx != {IDX_W{1'b0}}) && (wb_idx == src);
    endfunction

endpackage

// File: rtl/operand_fetch_if.sv
// operand_fetch_if: bundles the decode-side request, the writeback port and
// the alu_core-side result of the operand fetch stage.
//   master modport: the environment (decode, writeback source, alu_core)
//   slave modport : the operand_fetch stage itself
interface operand_fetch_if;
    import processor_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic [IDX_W-1:0]      in_rs1_idx;
    logic [IDX_W-1:0]      in_rs2_idx;
    logic [IDX_W-1:0]      in_rd_idx;
    logic [ALU_CTRL_W-1:0] in_alu_control;
    logic                  in_use_imm;
    logic [XLEN-1:0]       in_imm;

    logic                  wb_en;
    logic [IDX_W-1:0]      wb_idx;
    logic [XLEN-1:0]       wb_data;

    logic                  out_valid;
    logic                  out_ready;
    logic [XLEN-1:0]       out_rs1_val;
    logic [XLEN-1:0]       out_rs2_val;
    logic [ALU_CTRL_W-1:0] out_alu_control;
    logic [IDX_W-1:0]      out_rd_idx;

    modport master (
        output in_valid, in_rs1_idx, in_rs2_idx, in_rd_idx, in_alu_control,
               in_use_imm, in_imm, wb_en, wb_idx, wb_data, out_ready,
        input  in_ready, out_valid, out_rs1_val, out_rs2_val,
               out_alu_control, out_rd_idx
    );

    modport slave (
        input  in_valid, in_rs1_idx, in_rs2_idx, in_rd_idx, in_alu_control,
               in_use_imm, in_imm, wb_en, wb_idx, wb_data, out_ready,
        output in_ready, out_valid, out_rs1_val, out_rs2_val,
               out_alu_control, out_rd_idx
    );

endinterface

// File: rtl/operand_fetch_reg_file.sv
// reg_file: NREGS x XLEN integer register file.
//   clk, rst_n           clock, asynchronous active-low clear of all registers
//   rd_idx_a / rd_data_a asynchronous read port A
//   rd_idx_b / rd_data_b asynchronous read port B
//   wr_en, wr_idx, wr_data synchronous write port (writes to x0 dropped)
module reg_file
    import processor_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx_a,
    output logic [XLEN-1:0]  rd_data_a,
    input  logic [IDX_W-1:0] rd_idx_b,
    output logic [XLEN-1:0]  rd_data_b,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [XLEN-1:0]  wr_data
);

    logic [XLEN-1:0] regs_r [NREGS];

    // Storage: cleared on reset, written on the clock edge except for x0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_r[i] <= {XLEN{1'b0}};
            end
        end else if (wr_en && (wr_idx != {IDX_W{1'b0}})) begin
            regs_r[wr_idx] <= wr_data;
        end
    end

    // Read ports: x0 is forced to zero independent of storage contents.
    always_comb begin
        rd_data_a = {XLEN{1'b0}};
        rd_data_b = {XLEN{1'b0}};
        if (rd_idx_a != {IDX_W{1'b0}}) begin
            rd_data_a = regs_r[rd_idx_a];
        end else begin
            rd_data_a = {XLEN{1'b0}};
        end
        if (rd_idx_b != {IDX_W{1'b0}}) begin
            rd_data_b = regs_r[rd_idx_b];
        end else begin
            rd_data_b = {XLEN{1'b0}};
        end
    end

endmodule

// File: rtl/operand_fetch.sv
// operand_fetch: register-read stage feeding alu_core.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (clears register file and output stage)
//   bus    operand_fetch_if.slave: decoded op in (valid/ready), writeback port,
//          registered operands out (valid/ready) to alu_core
// Build option OPERAND_FETCH_BYPASS_EN:
//   defined   - a same-cycle writeback to a used source is forwarded, never stalls
//   undefined - such an op is held off one cycle until the write has landed
// Either way the captured operand values are the same; only timing differs.
module operand_fetch
    import processor_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    operand_fetch_if.slave  bus
);

    of_req_t               req_s;
    logic [XLEN-1:0]       rf_rs1_s;
    logic [XLEN-1:0]       rf_rs2_s;
    logic                  rs1_hit_s;
    logic                  rs2_hit_s;
    logic                  stall_s;
    logic [XLEN-1:0]       rs1_val_s;
    logic [XLEN-1:0]       rs2_val_s;
    logic                  in_ready_s;
    logic                  accept_s;

    logic                  out_valid_r;
    logic [XLEN-1:0]       out_rs1_val_r;
    logic [XLEN-1:0]       out_rs2_val_r;
    logic [ALU_CTRL_W-1:0] out_alu_control_r;
    logic [IDX_W-1:0]      out_rd_idx_r;

    reg_file u_reg_file (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_idx_a  (req_s.rs1),
        .rd_data_a (rf_rs1_s),
        .rd_idx_b  (req_s.rs2),
        .rd_data_b (rf_rs2_s),
        .wr_en     (bus.wb_en),
        .wr_idx    (bus.wb_idx),
        .wr_data   (bus.wb_data)
    );

    // Request packing, hazard detection, operand selection and handshake.
    always_comb begin
        req_s.rs1         = bus.in_rs1_idx;
        req_s.rs2         = bus.in_rs2_idx;
        req_s.rd          = bus.in_rd_idx;
        req_s.alu_control = bus.in_alu_control;
        req_s.use_imm     = bus.in_use_imm;
        req_s.imm         = bus.in_imm;

        rs1_hit_s = src_hit(bus.wb_en, bus.wb_idx, req_s.rs1);
        // An immediate op does not read rs2, so rs2 cannot be a hazard.
        rs2_hit_s = src_hit(bus.wb_en, bus.wb_idx, req_s.rs2) && !req_s.use_imm;

`ifdef OPERAND_FETCH_BYPASS_EN
        stall_s = 1'b0;
        if (rs1_hit_s) begin
            rs1_val_s = bus.wb_data;
        end else begin
            rs1_val_s = rf_rs1_s;
        end
        if (rs2_hit_s) begin
            rs2_val_s = bus.wb_data;
        end else begin
            rs2_val_s = rf_rs2_s;
        end
`else
        // in_valid is deliberately left out so in_ready never depends on it;
        // when in_valid is low the ready value is irrelevant anyway.
        stall_s   = rs1_hit_s || rs2_hit_s;
        rs1_val_s = rf_rs1_s;
        rs2_val_s = rf_rs2_s;
`endif

        if (req_s.use_imm) begin
            rs2_val_s = req_s.imm;
        end else begin
            rs2_val_s = rs2_val_s;
        end

        // Held low throughout reset so nothing is taken while clearing.
        in_ready_s = rst_n && (!out_valid_r || bus.out_ready) && !stall_s;
        accept_s   = bus.in_valid && in_ready_s;
    end

    // One-deep output register: loads on accept, empties on drain, else holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r       <= 1'b0;
            out_rs1_val_r     <= {XLEN{1'b0}};
            out_rs2_val_r     <= {XLEN{1'b0}};
            out_alu_control_r <= {ALU_CTRL_W{1'b0}};
            out_rd_idx_r      <= {IDX_W{1'b0}};
        end else if (accept_s) begin
            out_valid_r       <= 1'b1;
            out_rs1_val_r     <= rs1_val_s;
            out_rs2_val_r     <= rs2_val_s;
            out_alu_control_r <= req_s.alu_control;
            out_rd_idx_r      <= req_s.rd;
        end else if (out_valid_r && bus.out_ready) begin
            out_valid_r       <= 1'b0;
        end
    end

    assign bus.in_ready        = in_ready_s;
    assign bus.out_valid       = out_valid_r;
    assign bus.out_rs1_val     = out_rs1_val_r;
    assign bus.out_rs2_val     = out_rs2_val_r;
    assign bus.out_alu_control = out_alu_control_r;
    assign bus.out_rd_idx      = out_rd_idx_r;

endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: scoreboard bench for operand_fetch. The driver models the
// architectural register file as a plain array and pushes the expected result
// of every accepted op; an independent monitor compares whatever the DUT
// presents against the queue head and pops it on a downstream handshake.
module tb_operand_fetch;
    import processor_pkg::*;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  alu;
        logic [4:0]  rd;
    } exp_t;

    logic clk;
    logic rst_n;
    operand_fetch_if ifc ();

    operand_fetch dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    exp_t        sb[$];
    logic [31:0] ref_regs [32];
    logic        exp_valid = 1'b0;

    function automatic logic [31:0] model_read(input int idx, input logic we,
                                               input int wi, input logic [31:0] wd);
        if (idx == 0) return 32'h0;
        if (we && (wi == idx)) return wd;
        return ref_regs[idx];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) ref_regs[i] = 32'h0;
        exp_valid = 1'b0;
        sb.delete();
    endtask

    // One clock of stimulus: drive on the falling edge, check and model 1 ns later.
    task automatic step(input logic v, input int rs1, input int rs2, input int rd,
                        input int alu, input logic ui, input logic [31:0] imm,
                        input logic we, input int wi, input logic [31:0] wd,
                        input logic ordy, output logic acc);
        logic hz;
        logic stall_exp;
        exp_t e;
        @(negedge clk);
        ifc.in_valid       = v;
        ifc.in_rs1_idx     = 5'(rs1);
        ifc.in_rs2_idx     = 5'(rs2);
        ifc.in_rd_idx      = 5'(rd);
        ifc.in_alu_control = 5'(alu);
        ifc.in_use_imm     = ui;
        ifc.in_imm         = imm;
        ifc.wb_en          = we;
        ifc.wb_idx         = 5'(wi);
        ifc.wb_data        = wd;
        ifc.out_ready      = ordy;
        #1;
        hz = we && (wi != 0) && ((wi == rs1) || (!ui && (wi == rs2)));
`ifdef OPERAND_FETCH_BYPASS_EN
        stall_exp = 1'b0;
`else
        stall_exp = hz;
`endif
        check("out_valid", {31'h0, ifc.out_valid}, {31'h0, exp_valid});
        if (v) check("in_ready", {31'h0, ifc.in_ready},
                     {31'h0, (!exp_valid || ordy) && !stall_exp});
        acc = v && ifc.in_ready;
        if (acc) begin
            e.a   = model_read(rs1, we, wi, wd);
            e.b   = ui ? imm : model_read(rs2, we, wi, wd);
            e.alu = 5'(alu);
            e.rd  = 5'(rd);
            sb.push_back(e);
            exp_valid = 1'b1;
        end else if (exp_valid && ordy) begin
            exp_valid = 1'b0;
        end
        if (we && (wi != 0)) ref_regs[wi] = wd;
    endtask

    // Offer an op until accepted (writeback only on the first offer).
    task automatic send_op(input int rs1, input int rs2, input int rd, input int alu,
                           input logic ui, input logic [31:0] imm, input logic we,
                           input int wi, input logic [31:0] wd, input logic ordy);
        logic acc;
        acc = 1'b0;
        for (int t = 0; t < 4 && !acc; t++) begin
            if (t == 0) step(1'b1, rs1, rs2, rd, alu, ui, imm, we, wi, wd, ordy, acc);
            else        step(1'b1, rs1, rs2, rd, alu, ui, imm, 1'b0, 0, 32'h0, ordy, acc);
        end
        check("accept_timeout", {31'h0, acc}, 32'h1);
    endtask

    task automatic idle(input logic ordy, input logic we, input int wi, input logic [31:0] wd);
        logic acc;
        step(1'b0, 0, 0, 0, 0, 1'b0, 32'h0, we, wi, wd, ordy, acc);
    endtask

    // Monitor: compare the presented op with the queue head; pop on handshake.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && ifc.out_valid) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_output: got out_valid=1 expected no pending op");
                end else begin
                    check("out_rs1_val", ifc.out_rs1_val, sb[0].a);
                    check("out_rs2_val", ifc.out_rs2_val, sb[0].b);
                    check("out_alu_control", {27'h0, ifc.out_alu_control}, {27'h0, sb[0].alu});
                    check("out_rd_idx", {27'h0, ifc.out_rd_idx}, {27'h0, sb[0].rd});
                    if (ifc.out_ready) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc;
        rst_n              = 1'b0;
        ifc.in_valid       = 1'b0;
        ifc.in_rs1_idx     = 5'h0;
        ifc.in_rs2_idx     = 5'h0;
        ifc.in_rd_idx      = 5'h0;
        ifc.in_alu_control = 5'h0;
        ifc.in_use_imm     = 1'b0;
        ifc.in_imm         = 32'h0;
        ifc.wb_en          = 1'b0;
        ifc.wb_idx         = 5'h0;
        ifc.wb_data        = 32'h0;
        ifc.out_ready      = 1'b1;
        model_reset();

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_out_valid", {31'h0, ifc.out_valid}, 32'h0);
        check("rst_in_ready", {31'h0, ifc.in_ready}, 32'h0);
        check("rst_out_rs1", ifc.out_rs1_val, 32'h0);
        check("rst_out_rs2", ifc.out_rs2_val, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Read every register after reset.
        for (int i = 1; i < 32; i++) send_op(i, 32 - i, i, i, 1'b0, 32'h0, 1'b0, 0, 32'h0, 1'b1);
        idle(1'b1, 1'b0, 0, 32'h0);

        // Writeback then read; x0 write ignored.
        idle(1'b1, 1'b1, 5, 32'hDEADBEEF);
        send_op(5, 0, 1, 3, 1'b0, 32'h0, 1'b0, 0, 32'h0, 1'b1);
        idle(1'b1, 1'b1, 0, 32'h00001234);
        send_op(0, 5, 2, 4, 1'b0, 32'h0, 1'b0, 0, 32'h0, 1'b1);

        // Same-cycle hazard on rs1.
        send_op(7, 0, 3, 5, 1'b0, 32'h0, 1'b1, 7, 32'h00000055, 1'b1);
        // Same-cycle hazard on rs2.
        send_op(1, 7, 4, 6, 1'b0, 32'h0, 1'b1, 7, 32'h00000077, 1'b1);

        // Immediate op with rs2 being written: never stalls.
        step(1'b1, 3, 7, 5, 7, 1'b1, 32'hFFFFFFF0, 1'b1, 7, 32'h00000099, 1'b1, acc);
        check("imm_no_stall", {31'h0, acc}, 32'h1);
        idle(1'b1, 1'b0, 0, 32'h0);

        // Backpressure: one op held, later writebacks must not leak in.
        send_op(7, 5, 6, 8, 1'b0, 32'h0, 1'b0, 0, 32'h0, 1'b0);
        for (int c = 0; c < 3; c++) step(1'b1, 2, 3, 7, 9, 1'b0, 32'h0, 1'b1, 7, 32'h1000 + c, 1'b0, acc);
        for (int c = 0; c < 4; c++) send_op(7, c, 8 + c, 10 + c, 1'b0, 32'h0, 1'b0, 0, 32'h0, 1'b1);
        idle(1'b1, 1'b0, 0, 32'h0);

        // Randomized traffic, indices biased low to provoke hazards.
        for (int n = 0; n < 600; n++) begin
            step($urandom_range(0, 3) != 0,
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 6)),
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 6)),
                 int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                 $urandom_range(0, 3) == 0, $urandom(),
                 $urandom_range(0, 1) == 1, int'($urandom_range(0, 6)), $urandom(),
                 $urandom_range(0, 3) != 0, acc);
        end
        for (int n = 0; n < 3; n++) idle(1'b1, 1'b0, 0, 32'h0);
        check("drain_empty", sb.size(), 32'h0);

        // Reset while an op is pending and a writeback is in flight.
        send_op(1, 2, 3, 4, 1'b0, 32'h0, 1'b0, 0, 32'h0, 1'b0);
        @(negedge clk);
        ifc.in_valid  = 1'b0;
        ifc.out_ready = 1'b0;
        ifc.wb_en     = 1'b1;
        ifc.wb_idx    = 5'd9;
        ifc.wb_data   = 32'hCAFEF00D;
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {31'h0, ifc.out_valid}, 32'h0);
        check("midrst_in_ready", {31'h0, ifc.in_ready}, 32'h0);
        check("midrst_out_rs1", ifc.out_rs1_val, 32'h0);
        model_reset();
        @(negedge clk);
        ifc.wb_en = 1'b0;
        rst_n     = 1'b1;
        send_op(9, 9, 1, 1, 1'b0, 32'h0, 1'b0, 0, 32'h0, 1'b1);
        for (int n = 0; n < 2; n++) idle(1'b1, 1'b0, 0, 32'h0);
        check("final_empty", sb.size(), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
